math_arbiter: RTL and testbench
===============================

# math_arbiter

Shares one combinational math datapath between two requesters. Each requester has a valid/ready command port and a valid/ready response port. The block arbitrates between them round-robin, latches the winner's operands and opcode, holds them on the datapath for a configurable settle time, captures the 16-bit result and returns it to the winner. It sits between the bus-facing register blocks and the math datapath; it also counts completed operations.

## Interface
Parameters:
- EXEC_CYCLES, 1 — cycles operands are held on the datapath before the result is captured; legal range 1–15.

Ports:
- clk  in  1  — clock.
- rst  in  1  — reset, asynchronous, active-high.
- req0_valid / req1_valid  in  1  — command present.
- req0_ready / req1_ready  out  1  — command accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  8  — operands.
- req0_op / req1_op  in  4  — opcode; passed through unchanged, not decoded.
- rsp0_valid / rsp1_valid  out  1  — result available.
- rsp0_ready / rsp1_ready  in  1  — requester takes the result.
- rsp_result  out  16  — captured result, shared by both response ports.
- math_a, math_b  out  8  — datapath operands (registered).
- math_op  out  4  — datapath opcode (registered).
- math_result  in  16  — datapath output (combinational).
- busy  out  1  — high when state is not IDLE.
- done_count  out  8  — completed-operation counter.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant rule: if exactly one reqN_valid is high, it wins. If both are high, the requester not granted last time wins. The last-grant pointer resets to 1, so req0 wins the first tie.
  - reqN_ready is combinational: state==IDLE and grant==N. It is never high for both ports and never high outside IDLE.
  - On accept: latch a, b and op into math_a, math_b and math_op; record the owner; load the exec counter with EXEC_CYCLES-1; go to EXEC.
- EXEC:
  - math_* stay stable.
  - While the counter is nonzero, decrement it.
  - When the counter is zero, capture math_result into rsp_result and go to RESP.
- RESP:
  - rsp<owner>_valid is high and the other response valid is low.
  - rsp_result and math_* hold until rsp<owner>_ready is high.
  - On the handshake: done_count increments, wrapping 255→0; the last-grant pointer is set to the owner; go to IDLE.
- Arbitration is skipped while not IDLE. Requests that arrive during EXEC or RESP wait; they are not lost as long as the requester keeps valid high.
- The block does no arithmetic checking. Opcodes are passed through unchanged, and datapath conventions such as divide-by-zero returning 0xFFFF pass through as-is.

## Timing
- Reset (async assert, sync release), all outputs and state:
  - state=IDLE, math_a=math_b=0, math_op=0, rsp_result=0.
  - rspN_valid=0, busy=0, done_count=0, last-grant=1.
  - reqN_ready follows IDLE arbitration immediately after release.
- Reset mid-operation aborts the in-flight command: no response is issued and done_count is not incremented.
- Latency (accept edge = end of cycle 0):
  - Cycles 1..EXEC_CYCLES are EXEC.
  - The result is captured at the end of cycle EXEC_CYCLES.
  - rsp_valid is high from cycle EXEC_CYCLES+1.
  - With the default parameter, rsp_valid is first high in cycle 2.
- Throughput: if rsp_ready is held high, a new accept is possible EXEC_CYCLES+2 cycles after the previous accept.
- busy is high from cycle 1 through the response handshake cycle.
- If rsp_ready is already high when rsp_valid rises, the handshake completes in that same cycle.

## Test plan
- Single ADD: req0 a=0x12, b=0x34, op=0; rsp0_ready=1. Expect req0_ready in cycle 0, rsp0_valid in cycle 2 only, rsp_result=0x0046, done_count=1.
- Tie alternation: both valid continuously, req0 MUL 0x10×0x10, req1 SUB 0x05−0x07. Expect grant order req0, req1, req0. Results 0x0100 to rsp0 and 0xFFFE to rsp1.
- Backpressure: rsp1_ready held low for 5 cycles after rsp1_valid rises. Expect rsp1_valid, rsp_result and math_* stable, busy=1, req0_ready=0 throughout. When ready rises: accept, then IDLE next cycle.
- EXEC_CYCLES=3 with DIV 0x64/0x00. Expect math_* stable for cycles 1–3, rsp_valid in cycle 4, rsp_result=0xFFFF.
- Reset during EXEC: assert rst in cycle 1. Expect all outputs at reset values immediately, no rspN_valid, done_count=0.
- Counter wrap: 256 back-to-back operations. Expect done_count 255→0 on the 256th handshake.

Source files
------------

// File: rtl/math_arbiter.sv
// math_arbiter: round-robin sharing of one combinational math datapath
// between two valid/ready requesters. The winner's operands are held on the
// datapath for EXEC_CYCLES cycles, the result is captured and returned on the
// winner's response port, and completed operations are counted.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | arbitrating; the granted requester's ready is high
// EXEC  | operands held on the datapath, settle counter running down
// RESP  | captured result offered on the owner's response port
module math_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  input  logic [3:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp_result,
  output logic [7:0]  math_a,
  output logic [7:0]  math_b,
  output logic [3:0]  math_op,
  input  logic [15:0] math_result,
  output logic        busy,
  output logic [7:0]  done_count
);

  generate
    if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_bad_exec_cycles
      $error("math_arbiter: EXEC_CYCLES must be within 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Counter is loaded with EXEC_CYCLES-1 so the zero compare lands on the
  // last settle cycle.
  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic       last_grant;
  logic       owner;
  logic       grant_sel;
  logic       accept;
  logic       rsp_fire;
  logic [3:0] exec_cnt;

  // Round-robin pick: a lone requester wins; on a tie the one not granted
  // last time wins.
  always_comb begin
    grant_sel = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_sel = ~last_grant;
    end else if (req1_valid) begin
      grant_sel = 1'b1;
    end
  end

  // Handshake strobes and status outputs derived from the current state.
  always_comb begin
    req0_ready = (state == S_IDLE) && req0_valid && !grant_sel;
    req1_ready = (state == S_IDLE) && req1_valid && grant_sel;
    rsp0_valid = (state == S_RESP) && !owner;
    rsp1_valid = (state == S_RESP) && owner;
    busy       = (state != S_IDLE);
    accept     = req0_ready || req1_ready;
    rsp_fire   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_EXEC;
      S_EXEC: if (exec_cnt == 4'd0) state_nxt = S_RESP;
      S_RESP: if (rsp_fire) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand latch, settle counter, result capture and completion bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      math_a     <= 8'd0;
      math_b     <= 8'd0;
      math_op    <= 4'd0;
      owner      <= 1'b0;
      exec_cnt   <= 4'd0;
      rsp_result <= 16'd0;
      done_count <= 8'd0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            math_a   <= grant_sel ? req1_a  : req0_a;
            math_b   <= grant_sel ? req1_b  : req0_b;
            math_op  <= grant_sel ? req1_op : req0_op;
            owner    <= grant_sel;
            exec_cnt <= EXEC_LOAD;
          end
        end
        S_EXEC: begin
          if (exec_cnt != 4'd0) begin
            exec_cnt <= exec_cnt - 4'd1;
          end else begin
            rsp_result <= math_result;
          end
        end
        S_RESP: begin
          if (rsp_fire) begin
            done_count <= done_count + 8'd1;
            last_grant <= owner;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_math_arbiter.sv
// Self-checking bench for math_arbiter: a default instance (EXEC_CYCLES=1)
// and a second instance with EXEC_CYCLES=3, each driving a behavioural model
// of the math datapath. Expected results are queued at accept time and
// compared when the response handshake happens.
module tb_math_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [15:0] rsp_result, math_result;
  logic [7:0]  math_a, math_b, done_count;
  logic [3:0]  math_op;
  logic        busy;

  logic        e_req0_valid, e_req0_ready, e_req1_valid, e_req1_ready;
  logic [7:0]  e_req0_a, e_req0_b, e_req1_a, e_req1_b;
  logic [3:0]  e_req0_op, e_req1_op;
  logic        e_rsp0_valid, e_rsp0_ready, e_rsp1_valid, e_rsp1_ready;
  logic [15:0] e_rsp_result, e_math_result;
  logic [7:0]  e_math_a, e_math_b, e_done_count;
  logic [3:0]  e_math_op;
  logic        e_busy;

  int passed = 0;
  int total  = 0;
  logic [16:0] sb[$];

  // Datapath model: 0 add, 1 sub, 2 mul, 3 div (divide by zero -> 0xFFFF).
  function automatic logic [15:0] calc(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] op);
    logic [15:0] wa, wb;
    wa = {8'h00, a};
    wb = {8'h00, b};
    case (op)
      4'd0:    return wa + wb;
      4'd1:    return wa - wb;
      4'd2:    return wa * wb;
      4'd3:    return (b == 8'h00) ? 16'hFFFF : (wa / wb);
      default: return {a, b};
    endcase
  endfunction

  assign math_result   = calc(math_a, math_b, math_op);
  assign e_math_result = calc(e_math_a, e_math_b, e_math_op);

  math_arbiter #(.EXEC_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result),
    .math_a(math_a), .math_b(math_b), .math_op(math_op),
    .math_result(math_result),
    .busy(busy), .done_count(done_count)
  );

  math_arbiter #(.EXEC_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(e_req0_valid), .req0_ready(e_req0_ready),
    .req0_a(e_req0_a), .req0_b(e_req0_b), .req0_op(e_req0_op),
    .req1_valid(e_req1_valid), .req1_ready(e_req1_ready),
    .req1_a(e_req1_a), .req1_b(e_req1_b), .req1_op(e_req1_op),
    .rsp0_valid(e_rsp0_valid), .rsp0_ready(e_rsp0_ready),
    .rsp1_valid(e_rsp1_valid), .rsp1_ready(e_rsp1_ready),
    .rsp_result(e_rsp_result),
    .math_a(e_math_a), .math_b(e_math_b), .math_op(e_math_op),
    .math_result(e_math_result),
    .busy(e_busy), .done_count(e_done_count)
  );

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    e_req0_valid = 0; e_req1_valid = 0; e_rsp0_ready = 0; e_rsp1_ready = 0;
    e_req0_a = 0; e_req0_b = 0; e_req0_op = 0; e_req1_a = 0; e_req1_b = 0; e_req1_op = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    @(negedge clk); #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    total++; if ({rsp0_valid, rsp1_valid} !== 2'b00) $display("FAIL reset_rsp_valid got %b exp 00", {rsp0_valid, rsp1_valid}); else passed++;
    total++; if ({math_a, math_b, math_op} !== 20'h0) $display("FAIL reset_math got %h exp 0", {math_a, math_b, math_op}); else passed++;
    total++; if (rsp_result !== 16'h0) $display("FAIL reset_rsp_result got %h exp 0", rsp_result); else passed++;
    total++; if (done_count !== 8'h0) $display("FAIL reset_done_count got %h exp 0", done_count); else passed++;
    total++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready got %b exp 00", {req0_ready, req1_ready}); else passed++;
    total++; if ({e_busy, e_done_count} !== 9'h0) $display("FAIL reset_dut3 got %h exp 0", {e_busy, e_done_count}); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_single_add();
    logic [16:0] ent;
    apply_reset();
    @(negedge clk);
    req0_a = 8'h12; req0_b = 8'h34; req0_op = 4'd0; req0_valid = 1; rsp0_ready = 1;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL add_ready_c0 got %b exp 10", {req0_ready, req1_ready}); else passed++;
    sb.push_back({1'b0, calc(8'h12, 8'h34, 4'd0)});
    @(negedge clk);
    req0_valid = 0; #1;
    total++; if ({busy, rsp0_valid} !== 2'b10) $display("FAIL add_c1 busy/rsp got %b exp 10", {busy, rsp0_valid}); else passed++;
    @(negedge clk); #1;
    total++; if (rsp0_valid !== 1'b1) $display("FAIL add_rsp_c2 got %b exp 1", rsp0_valid); else passed++;
    ent = sb.pop_front();
    total++; if (rsp_result !== ent[15:0] || rsp_result !== 16'h0046) $display("FAIL add_result got %h exp %h", rsp_result, ent[15:0]); else passed++;
    @(negedge clk); #1;
    total++; if ({rsp0_valid, busy} !== 2'b00) $display("FAIL add_c3 rsp/busy got %b exp 00", {rsp0_valid, busy}); else passed++;
    total++; if (done_count !== 8'd1) $display("FAIL add_done_count got %0d exp 1", done_count); else passed++;
  endtask

  task automatic test_tie();
    int grants[$];
    logic [16:0] ent;
    bit fin = 0;
    apply_reset();
    @(negedge clk);
    req0_a = 8'h10; req0_b = 8'h10; req0_op = 4'd2; req0_valid = 1;
    req1_a = 8'h05; req1_b = 8'h07; req1_op = 4'd1; req1_valid = 1;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (grants.size() >= 3) begin req0_valid = 0; req1_valid = 0; end
      #1;
      total++; if (req0_ready && req1_ready) $display("FAIL tie_both_ready got 11 exp not both"); else passed++;
      if (req0_ready) begin grants.push_back(0); sb.push_back({1'b0, calc(req0_a, req0_b, req0_op)}); end
      if (req1_ready) begin grants.push_back(1); sb.push_back({1'b1, calc(req1_a, req1_b, req1_op)}); end
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        total++;
        if (sb.size() == 0) $display("FAIL tie_unexpected_rsp got rsp exp none");
        else begin
          ent = sb.pop_front();
          if ({rsp1_valid, rsp_result} !== ent) $display("FAIL tie_rsp got owner %b res %h exp owner %b res %h", rsp1_valid, rsp_result, ent[16], ent[15:0]);
          else passed++;
        end
      end
      if (grants.size() >= 3 && sb.size() == 0 && !busy) fin = 1;
    end
    total++; if (!fin) $display("FAIL tie_timeout got %0d grants exp 3", grants.size()); else passed++;
    total++;
    if (grants.size() != 3 || grants[0] != 0 || grants[1] != 1 || grants[2] != 0)
      $display("FAIL tie_order got %p exp '{0,1,0}", grants);
    else passed++;
    total++; if (done_count !== 8'd3) $display("FAIL tie_done_count got %0d exp 3", done_count); else passed++;
  endtask

  task automatic test_backpressure();
    logic [16:0] ent;
    bit seen = 0;
    apply_reset();
    @(negedge clk);
    req1_a = 8'h21; req1_b = 8'h43; req1_op = 4'd1; req1_valid = 1;
    #1;
    total++; if (req1_ready !== 1'b1) $display("FAIL bp_accept got %b exp 1", req1_ready); else passed++;
    sb.push_back({1'b1, calc(8'h21, 8'h43, 4'd1)});
    @(negedge clk);
    req1_valid = 0; req1_a = 8'hAA;
    req0_a = 8'h03; req0_b = 8'h04; req0_op = 4'd0; req0_valid = 1;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (rsp1_valid) seen = 1;
    end
    total++; if (!seen) $display("FAIL bp_rsp_timeout got no rsp1_valid exp rsp1_valid"); else passed++;
    if (!seen) return;
    ent = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp1_valid, rsp0_valid, busy, req0_ready} !== 4'b1010 || rsp_result !== ent[15:0] ||
          {math_a, math_b, math_op} !== {8'h21, 8'h43, 4'd1})
        $display("FAIL bp_hold c%0d got v1 %b v0 %b busy %b r0 %b res %h math %h exp 1 0 1 0 %h %h",
                 i, rsp1_valid, rsp0_valid, busy, req0_ready, rsp_result, {math_a, math_b, math_op},
                 ent[15:0], {8'h21, 8'h43, 4'd1});
      else passed++;
      @(negedge clk); #1;
    end
    rsp1_ready = 1; #1;
    total++; if (rsp1_valid !== 1'b1 || rsp_result !== 16'hFFDE) $display("FAIL bp_handshake got %b %h exp 1 ffde", rsp1_valid, rsp_result); else passed++;
    @(negedge clk); #1;
    total++; if ({busy, rsp1_valid, req0_ready} !== 3'b001) $display("FAIL bp_idle got %b exp 001", {busy, rsp1_valid, req0_ready}); else passed++;
    total++; if (done_count !== 8'd1) $display("FAIL bp_done_count got %0d exp 1", done_count); else passed++;
    req0_valid = 0; rsp1_ready = 0;
  endtask

  task automatic test_exec3();
    logic [16:0] ent;
    apply_reset();
    @(negedge clk);
    e_req0_a = 8'h64; e_req0_b = 8'h00; e_req0_op = 4'd3; e_req0_valid = 1; e_rsp0_ready = 1;
    #1;
    total++; if (e_req0_ready !== 1'b1) $display("FAIL ex3_accept got %b exp 1", e_req0_ready); else passed++;
    sb.push_back({1'b0, calc(8'h64, 8'h00, 4'd3)});
    @(negedge clk);
    e_req0_valid = 0; e_req0_a = 8'h00; e_req0_op = 4'd0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      total++;
      if ({e_math_a, e_math_b, e_math_op} !== {8'h64, 8'h00, 4'd3} || e_rsp0_valid !== 1'b0 || e_busy !== 1'b1)
        $display("FAIL ex3_hold c%0d got math %h rsp %b busy %b exp 64003 0 1", c, {e_math_a, e_math_b, e_math_op}, e_rsp0_valid, e_busy);
      else passed++;
      @(negedge clk);
    end
    #1;
    total++; if (e_rsp0_valid !== 1'b1) $display("FAIL ex3_rsp_c4 got %b exp 1", e_rsp0_valid); else passed++;
    ent = sb.pop_front();
    total++; if (e_rsp_result !== ent[15:0] || e_rsp_result !== 16'hFFFF) $display("FAIL ex3_result got %h exp ffff", e_rsp_result); else passed++;
    @(negedge clk); #1;
    total++; if ({e_busy, e_done_count} !== {1'b0, 8'd1}) $display("FAIL ex3_done got busy %b cnt %0d exp 0 1", e_busy, e_done_count); else passed++;
    e_rsp0_ready = 0;
  endtask

  task automatic test_reset_exec();
    bit saw_rsp = 0;
    apply_reset();
    @(negedge clk);
    req0_a = 8'h77; req0_b = 8'h11; req0_op = 4'd0; req0_valid = 1; rsp0_ready = 1;
    #1;
    total++; if (req0_ready !== 1'b1) $display("FAIL rx_accept got %b exp 1", req0_ready); else passed++;
    @(negedge clk);
    req0_valid = 0; #1;
    total++; if (busy !== 1'b1) $display("FAIL rx_busy_c1 got %b exp 1", busy); else passed++;
    rst = 1'b1; #1;
    total++;
    if ({busy, rsp0_valid, rsp1_valid} !== 3'b000 || {math_a, math_b, math_op} !== 20'h0 ||
        rsp_result !== 16'h0 || done_count !== 8'h0)
      $display("FAIL rx_reset_values got busy %b rsp %b%b math %h res %h cnt %0d exp all 0",
               busy, rsp0_valid, rsp1_valid, {math_a, math_b, math_op}, rsp_result, done_count);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (rsp0_valid || rsp1_valid) saw_rsp = 1;
    end
    total++; if (saw_rsp) $display("FAIL rx_no_rsp got rsp_valid exp none"); else passed++;
    total++; if (done_count !== 8'h0) $display("FAIL rx_done_count got %0d exp 0", done_count); else passed++;
  endtask

  task automatic test_back_to_back_wrap();
    logic [16:0] ent;
    logic [7:0] model = 8'd0;
    int accepts = 0, hs = 0, last_acc = 0;
    bit saw255 = 0;
    apply_reset();
    rsp0_ready = 1;
    for (int cyc = 0; cyc < 1500 && hs < 256; cyc++) begin
      @(negedge clk);
      req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 4'($urandom_range(0, 3));
      req0_valid = (accepts < 256);
      #1;
      total++; if (done_count !== model) $display("FAIL wrap_done_count c%0d got %0d exp %0d", cyc, done_count, model); else passed++;
      if (req0_ready) begin
        sb.push_back({1'b0, calc(req0_a, req0_b, req0_op)});
        if (accepts > 0) begin
          total++; if (cyc - last_acc != 3) $display("FAIL wrap_throughput got gap %0d exp 3", cyc - last_acc); else passed++;
        end
        last_acc = cyc;
        accepts++;
      end
      if (rsp0_valid && rsp0_ready) begin
        total++;
        if (sb.size() == 0) $display("FAIL wrap_unexpected_rsp got rsp exp none");
        else begin
          ent = sb.pop_front();
          if (rsp_result !== ent[15:0]) $display("FAIL wrap_result got %h exp %h", rsp_result, ent[15:0]);
          else passed++;
        end
        if (done_count == 8'd255) saw255 = 1;
        hs++;
        model = model + 8'd1;
      end
    end
    req0_valid = 0;
    @(negedge clk); #1;
    total++; if (hs != 256) $display("FAIL wrap_handshakes got %0d exp 256", hs); else passed++;
    total++; if (done_count !== 8'h00 || !saw255) $display("FAIL wrap_rollover got %0d saw255 %b exp 0 1", done_count, saw255); else passed++;
    rsp0_ready = 0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_add();
    test_tie();
    test_backpressure();
    test_exec3();
    test_reset_exec();
    test_back_to_back_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
